// File: rtl/jk_bank_ctrl.sv
// Purpose : command sequencer driving the J/K inputs of an external JK flop bank, then verifying its Q.
// Latency : done pulses in the cycle after edge A+N+1 (A = accept edge, N = drive cycles; 0 for NOP/illegal).
// Backpres: cmd_ready is high only while idle; a held cmd_valid is taken in the cycle done is high.
module jk_bank_ctrl #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_mask,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [CNT_W-1:0] cmd_steps,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k,
   input  logic [WIDTH-1:0] q,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] q_snap
);

   localparam logic [2:0] OP_NOP    = 3'd0;
   localparam logic [2:0] OP_CLEAR  = 3'd1;
   localparam logic [2:0] OP_SET    = 3'd2;
   localparam logic [2:0] OP_TOGGLE = 3'd3;
   localparam logic [2:0] OP_LOAD   = 3'd4;
   localparam logic [2:0] OP_COUNT  = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_CHECK = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             accept;
   logic [2:0]       op_r;
   logic [WIDTH-1:0] mask_r;
   logic [WIDTH-1:0] data_r;
   logic [WIDTH-1:0] exp_r;
   logic             ill_r;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] n_cmd;
   logic [WIDTH-1:0] exp_cmd;
   logic             ill_cmd;
   logic [WIDTH-1:0] steps_w;
   logic             carry;

   // Ready is forced low while reset is asserted so nothing can be accepted during reset.
   assign cmd_ready = rst && (state == S_IDLE);
   assign accept    = cmd_valid && cmd_ready;
   // COUNT adds the step count modulo 2^WIDTH, so the count is resized to the bank width.
   assign steps_w   = WIDTH'(cmd_steps);

   // Decode the incoming command: drive length, expected final Q, illegal flag.
   always_comb begin
      n_cmd   = '0;
      exp_cmd = q;
      ill_cmd = 1'b0;
      case (cmd_op)
         OP_NOP: begin
            n_cmd   = '0;
            exp_cmd = q;
         end
         OP_CLEAR: begin
            n_cmd   = CNT_W'(1);
            exp_cmd = q & ~cmd_mask;
         end
         OP_SET: begin
            n_cmd   = CNT_W'(1);
            exp_cmd = q | cmd_mask;
         end
         OP_TOGGLE: begin
            n_cmd   = cmd_steps;
            exp_cmd = q ^ (cmd_mask & {WIDTH{cmd_steps[0]}});
         end
         OP_LOAD: begin
            n_cmd   = CNT_W'(1);
            exp_cmd = (q & ~cmd_mask) | (cmd_data & cmd_mask);
         end
         OP_COUNT: begin
            n_cmd   = cmd_steps;
            exp_cmd = q + steps_w;
         end
         default: ill_cmd = 1'b1;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Next-state: zero-length and illegal commands skip DRIVE.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) state_nxt = (n_cmd != '0) ? S_DRIVE : S_CHECK;
         end
         S_DRIVE: begin
            if (cnt_r == CNT_W'(1)) state_nxt = S_CHECK;
         end
         S_CHECK: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // J/K drive: only in DRIVE; everywhere else the bank holds.
   always_comb begin
      j     = '0;
      k     = '0;
      carry = 1'b1;
      if (state == S_DRIVE) begin
         case (op_r)
            OP_CLEAR: k = mask_r;
            OP_SET:   j = mask_r;
            OP_TOGGLE: begin
               j = mask_r;
               k = mask_r;
            end
            OP_LOAD: begin
               j = mask_r & data_r;
               k = mask_r & ~data_r;
            end
            OP_COUNT: begin
               for (int i = 0; i < WIDTH; i++) begin
                  j[i]  = carry;
                  k[i]  = carry;
                  carry = carry & q[i];
               end
            end
            default: begin
               j = '0;
               k = '0;
            end
         endcase
      end
   end

   // Latch the accepted command together with the Q it must produce.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_r   <= OP_NOP;
         mask_r <= '0;
         data_r <= '0;
         exp_r  <= '0;
         ill_r  <= 1'b0;
      end else if (accept) begin
         op_r   <= cmd_op;
         mask_r <= cmd_mask;
         data_r <= cmd_data;
         exp_r  <= exp_cmd;
         ill_r  <= ill_cmd;
      end
   end

   // Drive-cycle down-counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                   cnt_r <= '0;
      else if (accept)            cnt_r <= n_cmd;
      else if (state == S_DRIVE)  cnt_r <= cnt_r - CNT_W'(1);
   end

   // Completion: pulse done/err and snapshot Q on the edge leaving CHECK.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done   <= 1'b0;
         err    <= 1'b0;
         q_snap <= '0;
      end else begin
         done <= (state == S_CHECK);
         err  <= (state == S_CHECK) && ((q != exp_r) || ill_r);
         if (state == S_CHECK) q_snap <= q;
      end
   end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Bench for jk_bank_ctrl: JK bank model with optional stuck-at-0 bits, directed cases, random commands.
// A command-level model predicts ready/j/k/done/err/q_snap each cycle from the operation rules.
// Literal expectations on the directed cases pin that model.
module tb_jk_bank_ctrl;
   localparam int W  = 4;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid, cmd_ready;
   logic [2:0]    cmd_op;
   logic [W-1:0]  cmd_mask, cmd_data;
   logic [CW-1:0] cmd_steps;
   logic [W-1:0]  j, k, q, q_snap;
   logic          done, err;

   logic          bank_ld;
   logic [W-1:0]  bank_val, stuck0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   jk_bank_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_data(cmd_data), .cmd_steps(cmd_steps),
      .j(j), .k(k), .q(q), .done(done), .err(err), .q_snap(q_snap)
   );

   // External JK bank; stuck0 bits never leave 0.
   always @(posedge clk) begin
      if (bank_ld) q <= bank_val & ~stuck0;
      else         q <= ((j & ~q) | (~k & q)) & ~stuck0;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int n_of(input logic [2:0] op, input logic [CW-1:0] steps);
      if (op == 3'd1 || op == 3'd2 || op == 3'd4) return 1;
      if (op == 3'd3 || op == 3'd5) return int'(steps);
      return 0;
   endfunction

   function automatic logic [W-1:0] final_q(input logic [2:0] op, input logic [W-1:0] q0,
                                            input logic [W-1:0] m, input logic [W-1:0] d,
                                            input logic [CW-1:0] steps);
      case (op)
         3'd1: return q0 & ~m;
         3'd2: return q0 | m;
         3'd3: return (steps % 2 == 1) ? (q0 ^ m) : q0;
         3'd4: return (q0 & ~m) | (d & m);
         3'd5: return W'((int'(q0) + int'(steps)) % (1 << W));
         default: return q0;
      endcase
   endfunction

   // Returns {j,k}; for COUNT the flops that flip on an increment are exactly q ^ (q+1).
   function automatic logic [2*W-1:0] jk_of(input logic [2:0] op, input logic [W-1:0] m,
                                            input logic [W-1:0] d, input logic [W-1:0] qq);
      logic [W-1:0] inc;
      inc = qq + W'(1);
      case (op)
         3'd1: return {{W{1'b0}}, m};
         3'd2: return {m, {W{1'b0}}};
         3'd3: return {m, m};
         3'd4: return {m & d, m & ~d};
         3'd5: return {qq ^ inc, qq ^ inc};
         default: return '0;
      endcase
   endfunction

   int           cyc = 0;
   bit           m_active = 1'b0;
   int           m_A = 0, m_N = 0, m_done_cyc = -1;
   logic [2:0]   m_op;
   logic [W-1:0] m_mask, m_data, m_exp_snap, m_snap, m_fin;
   bit           m_exp_err;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_active   = 1'b0;
         m_done_cyc = -1;
         m_snap     = '0;
      end else begin
         cyc++;
         if (cyc == m_done_cyc) m_snap = m_exp_snap;
         if (!m_active && cmd_valid) begin
            m_A        = cyc;
            m_N        = n_of(cmd_op, cmd_steps);
            m_op       = cmd_op;
            m_mask     = cmd_mask;
            m_data     = cmd_data;
            m_fin      = final_q(cmd_op, q, cmd_mask, cmd_data, cmd_steps);
            m_exp_snap = m_fin & ~stuck0;
            m_exp_err  = (cmd_op > 3'd5) || (m_exp_snap != m_fin);
            m_done_cyc = cyc + m_N + 1;
            m_active   = 1'b1;
         end else if (m_active && cyc == m_A + m_N + 1) begin
            m_active = 1'b0;
         end
      end
   end

   logic [W-1:0] rec_snap;
   logic         rec_err;

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      logic [2*W-1:0] ejk;
      bit             drv;
      if (!rst) begin
         chk("rst_ready", 32'(cmd_ready), 32'(0));
         chk("rst_j", 32'(j), 32'(0));
         chk("rst_k", 32'(k), 32'(0));
         chk("rst_done", 32'(done), 32'(0));
         chk("rst_err", 32'(err), 32'(0));
         chk("rst_q_snap", 32'(q_snap), 32'(0));
      end else begin
         drv = m_active && (m_N > 0) && (cyc >= m_A) && (cyc < m_A + m_N);
         ejk = drv ? jk_of(m_op, m_mask, m_data, q) : '0;
         chk("ready", 32'(cmd_ready), 32'(!m_active));
         chk("j", 32'(j), 32'(ejk[2*W-1:W]));
         chk("k", 32'(k), 32'(ejk[W-1:0]));
         chk("done", 32'(done), 32'(cyc == m_done_cyc));
         chk("err", 32'(err), 32'((cyc == m_done_cyc) && m_exp_err));
         chk("q_snap", 32'(q_snap), 32'(m_snap));
         if (done) begin
            rec_snap = q_snap;
            rec_err  = err;
         end
      end
   end

   // ---------------- stimulus ----------------
   int last_acc = 0;

   task automatic wait_ready();
      int n = 0;
      while (!cmd_ready && n < 600) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         checks++;
         failures++;
         $display("FAIL ready_timeout actual=0 required=1");
      end
   endtask

   task automatic preset(input logic [W-1:0] v);
      wait_ready();
      bank_ld  = 1'b1;
      bank_val = v;
      @(negedge clk);
      bank_ld  = 1'b0;
   endtask

   task automatic send(input logic [2:0] op, input logic [W-1:0] m, input logic [W-1:0] d,
                       input logic [CW-1:0] steps);
      cmd_op    = op;
      cmd_mask  = m;
      cmd_data  = d;
      cmd_steps = steps;
      cmd_valid = 1'b1;
      wait_ready();
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      last_acc  = cyc;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 600) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL done_timeout actual=0 required=1");
      end
   endtask

   initial begin
      int a1, a2;
      bit seen;
      cmd_valid = 1'b0; cmd_op = '0; cmd_mask = '0; cmd_data = '0; cmd_steps = '0;
      bank_ld = 1'b1; bank_val = '0; stuck0 = '0;
      rst = 1'b1;
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("pin_reset_ready", 32'(cmd_ready), 32'(0));
      chk("pin_reset_q_snap", 32'(q_snap), 32'(0));
      bank_ld = 1'b0;
      #2 rst = 1'b1;
      @(negedge clk);

      // LOAD 1010 over 0000
      preset(4'b0000);
      send(3'd4, 4'b1111, 4'b1010, 8'd0);
      chk("pin_load_j", 32'(j), 32'(4'b1010));
      chk("pin_load_k", 32'(k), 32'(4'b0101));
      wait_done();
      chk("pin_load_snap", 32'(q_snap), 32'(4'b1010));
      chk("pin_load_err", 32'(err), 32'(0));
      chk("pin_load_lat", 32'(cyc - last_acc), 32'(2));

      // TOGGLE mask 0011 x3 over 1010
      preset(4'b1010);
      send(3'd3, 4'b0011, 4'b0000, 8'd3);
      chk("pin_tog_j", 32'(j), 32'(4'b0011));
      chk("pin_tog_k", 32'(k), 32'(4'b0011));
      wait_done();
      chk("pin_tog_snap", 32'(q_snap), 32'(4'b1001));
      chk("pin_tog_err", 32'(err), 32'(0));
      chk("pin_tog_lat", 32'(cyc - last_acc), 32'(4));

      // COUNT 5 from 1110 wraps
      preset(4'b1110);
      send(3'd5, 4'b0000, 4'b0000, 8'd5);
      chk("pin_cnt_ready", 32'(cmd_ready), 32'(0));
      wait_done();
      chk("pin_cnt_snap", 32'(q_snap), 32'(4'b0011));
      chk("pin_cnt_err", 32'(err), 32'(0));
      chk("pin_cnt_lat", 32'(cyc - last_acc), 32'(6));

      // illegal op
      preset(4'b0110);
      send(3'd7, 4'b1111, 4'b1111, 8'd9);
      chk("pin_ill_j", 32'(j), 32'(0));
      chk("pin_ill_k", 32'(k), 32'(0));
      wait_done();
      chk("pin_ill_err", 32'(err), 32'(1));
      chk("pin_ill_snap", 32'(q_snap), 32'(4'b0110));
      chk("pin_ill_q", 32'(q), 32'(4'b0110));

      // stuck bit 2, SET 0100, then back-to-back NOP
      preset(4'b0001);
      stuck0 = 4'b0100;
      send(3'd2, 4'b0100, 4'b0000, 8'd0);
      a1 = last_acc;
      send(3'd0, 4'b0000, 4'b0000, 8'd0);
      a2 = last_acc;
      chk("pin_b2b_gap", 32'(a2 - a1), 32'(3));
      chk("pin_stuck_err", 32'(rec_err), 32'(1));
      chk("pin_stuck_snap", 32'(rec_snap), 32'(4'b0001));
      wait_done();
      @(negedge clk);
      stuck0 = 4'b0000;

      // reset in the middle of COUNT 10
      preset(4'b0000);
      send(3'd5, 4'b0000, 4'b0000, 8'd10);
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("pin_abort_j", 32'(j), 32'(0));
      chk("pin_abort_k", 32'(k), 32'(0));
      chk("pin_abort_ready", 32'(cmd_ready), 32'(0));
      chk("pin_abort_snap", 32'(q_snap), 32'(0));
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      seen = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk("pin_abort_no_done", 32'(seen), 32'(0));
      chk("pin_abort_idle", 32'(cmd_ready), 32'(1));

      // random commands
      for (int it = 0; it < 250; it++) begin
         logic [CW-1:0] st;
         if ($urandom_range(0, 3) == 0) preset(W'($urandom));
         repeat ($urandom_range(0, 2)) @(negedge clk);
         st = ($urandom_range(0, 4) == 0) ? 8'd0 : CW'($urandom_range(1, 20));
         send(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), st);
      end
      wait_ready();
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
